// File: rtl/block_mult_scheduler.sv
// Sequencer for blocked matrix multiply C = A*B: walks output blocks (i,j) and inner blocks k,
// emitting skewed lane enables, accumulator clear, a drain window and a write-back handshake.
module block_mult_scheduler #(
  parameter int DIM       = 4,
  parameter int NB_W      = 4,
  parameter int DRAIN_CYC = 4,
  parameter int BEAT_W    = $clog2(2*DIM)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [NB_W-1:0]   nb,
  input  logic              stall,
  input  logic              wb_ready,
  output logic              busy,
  output logic              done,
  output logic [NB_W-1:0]   blk_i,
  output logic [NB_W-1:0]   blk_j,
  output logic [NB_W-1:0]   blk_k,
  output logic [BEAT_W-1:0] beat,
  output logic [DIM-1:0]    lane_en,
  output logic              acc_clear,
  output logic              wb_valid
);

  localparam int DC_W = $clog2(DRAIN_CYC) + 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(2*DIM-2);
  localparam logic [DC_W-1:0]   DC_LAST   = DC_W'(DRAIN_CYC-1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_DRAIN  = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [NB_W-1:0]   nb_q, nb_d;
  logic [NB_W-1:0]   i_q, i_d;
  logic [NB_W-1:0]   j_q, j_d;
  logic [NB_W-1:0]   k_q, k_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [DC_W-1:0]   dcnt_q, dcnt_d;

  // One extra bit so "index+1 vs nb" never wraps, even at nb = 2**NB_W-1.
  logic [NB_W:0] nb_ext, i_nxt, j_nxt, k_nxt;
  assign nb_ext = {1'b0, nb_q};
  assign i_nxt  = {1'b0, i_q} + {{NB_W{1'b0}}, 1'b1};
  assign j_nxt  = {1'b0, j_q} + {{NB_W{1'b0}}, 1'b1};
  assign k_nxt  = {1'b0, k_q} + {{NB_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    nb_d    = nb_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    beat_d  = beat_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          nb_d    = nb;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          beat_d  = '0;
          state_d = (nb != '0) ? S_STREAM : S_DONE;
        end
      end
      S_STREAM: begin
        if (!stall) begin
          if (beat_q == BEAT_LAST) begin
            beat_d = '0;
            if (k_nxt == nb_ext) begin
              state_d = S_DRAIN;
              dcnt_d  = '0;
            end else begin
              k_d = k_nxt[NB_W-1:0];
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          if (dcnt_q == DC_LAST) state_d = S_WRITE;
          else                   dcnt_d  = dcnt_q + DC_W'(1);
        end
      end
      S_WRITE: begin
        if (wb_ready) begin
          k_d = '0;
          if (j_nxt < nb_ext) begin
            j_d     = j_nxt[NB_W-1:0];
            state_d = S_STREAM;
          end else if (i_nxt < nb_ext) begin
            j_d     = '0;
            i_d     = i_nxt[NB_W-1:0];
            state_d = S_STREAM;
          end else begin
            i_d     = '0;
            j_d     = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      nb_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      beat_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      nb_q    <= nb_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      beat_q  <= beat_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign wb_valid = (state_q == S_WRITE);
  assign blk_i    = i_q;
  assign blk_j    = j_q;
  assign blk_k    = k_q;
  assign beat     = beat_q;

  // Lane l is fed on beats l..l+DIM-1, giving the diagonal skew into the array.
  always_comb begin
    lane_en   = '0;
    acc_clear = 1'b0;
    if (state_q == S_STREAM && !stall) begin
      for (int l = 0; l < DIM; l++)
        lane_en[l] = (int'(beat_q) >= l) && (int'(beat_q) < l + DIM);
      acc_clear = (k_q == '0) && (beat_q == '0);
    end
  end

endmodule

// File: tb/tb_block_mult_scheduler.sv
// Bench for block_mult_scheduler: each job is expanded into its expected step schedule
// (nested i/j/k/beat loops) and the DUT is compared against the head of that schedule every cycle.
module tb_block_mult_scheduler;

  localparam int DIM = 4;
  localparam int NB_W = 4;
  localparam int DRAIN_CYC = 4;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            start = 1'b0;
  logic [NB_W-1:0] nb_in = '0;
  logic            stall = 1'b0;
  logic            wb_ready = 1'b0;
  logic            busy, done, acc_clear, wb_valid;
  logic [NB_W-1:0] blk_i, blk_j, blk_k;
  logic [2:0]      beat;
  logic [DIM-1:0]  lane_en;

  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int ph;   // 0 stream, 1 drain, 2 write, 3 done
    int i;
    int j;
    int k;
    int b;
  } step_t;

  step_t sched_q[$];

  always #5 clock = ~clock;

  block_mult_scheduler #(.DIM(DIM), .NB_W(NB_W), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clock(clock), .reset(reset), .start(start), .nb(nb_in), .stall(stall),
    .wb_ready(wb_ready), .busy(busy), .done(done), .blk_i(blk_i), .blk_j(blk_j),
    .blk_k(blk_k), .beat(beat), .lane_en(lane_en), .acc_clear(acc_clear), .wb_valid(wb_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".done"}, 32'(done), 0);
    chk({tag, ".wbv"}, 32'(wb_valid), 0);
    chk({tag, ".lane"}, 32'(lane_en), 0);
    chk({tag, ".clr"}, 32'(acc_clear), 0);
    chk({tag, ".ijk"}, {20'd0, blk_i, blk_j, blk_k}, 0);
    chk({tag, ".beat"}, 32'(beat), 0);
  endtask

  task automatic build_sched(input int n);
    sched_q.delete();
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++) begin
        for (int k = 0; k < n; k++)
          for (int b = 0; b < 2*DIM-1; b++) sched_q.push_back('{0, i, j, k, b});
        for (int d = 0; d < DRAIN_CYC; d++) sched_q.push_back('{1, i, j, 0, 0});
        sched_q.push_back('{2, i, j, 0, 0});
      end
    sched_q.push_back('{3, 0, 0, 0, 0});
  endtask

  // stall_k >= 0: stall 3 cycles when the schedule reaches beat 2 of that k.
  // ready_hold: hold wb_ready low for that many cycles of the first write-back.
  task automatic run_job(input int n, input int stall_pct, input int ready_pct, input bit noise,
                         input int stall_k, input int ready_hold, input int abort_after,
                         input int exp_cycles);
    step_t s;
    logic [DIM-1:0] e_lane;
    int stall_left = 0;
    bit trig = 0;
    int hold_left = ready_hold;
    int cycles = 0;
    int busy_cnt = 0;
    bit adv;
    build_sched(n);
    @(negedge clock);
    start = 1'b1;
    nb_in = NB_W'(n);
    stall = 1'b0;
    #1 chk("pre_start.busy", 32'(busy), 0);
    while (sched_q.size() > 0) begin
      @(negedge clock);
      s = sched_q[0];
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      if (noise) nb_in = NB_W'($urandom_range(3));
      stall = ($urandom_range(99) < stall_pct);
      if (!trig && stall_k >= 0 && s.ph == 0 && s.k == stall_k && s.b == 2) begin
        trig = 1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end
      wb_ready = ($urandom_range(99) < ready_pct);
      if (s.ph == 2 && hold_left > 0) begin
        wb_ready = 1'b0;
        hold_left--;
      end
      #1;
      busy_cnt += int'(busy);
      for (int l = 0; l < DIM; l++)
        e_lane[l] = (s.ph == 0) && !stall && (l <= s.b) && (s.b < l + DIM);
      chk("busy", 32'(busy), 1);
      chk("done", 32'(done), 32'(s.ph == 3));
      chk("wb_valid", 32'(wb_valid), 32'(s.ph == 2));
      chk("blk_i", 32'(blk_i), 32'(s.i));
      chk("blk_j", 32'(blk_j), 32'(s.j));
      chk("lane_en", 32'(lane_en), 32'(e_lane));
      chk("acc_clear", 32'(acc_clear), 32'(s.ph == 0 && !stall && s.k == 0 && s.b == 0));
      if (s.ph == 0) begin
        chk("blk_k", 32'(blk_k), 32'(s.k));
        chk("beat", 32'(beat), 32'(s.b));
      end
      if (s.ph == 3) chk("done.blk_k", 32'(blk_k), 0);
      case (s.ph)
        0, 1:    adv = !stall;
        2:       adv = wb_ready;
        default: adv = 1'b1;
      endcase
      if (adv) void'(sched_q.pop_front());
      cycles++;
      if (abort_after > 0 && cycles == abort_after) break;
    end
    if (abort_after == 0) begin
      @(negedge clock);
      start = 1'b0;
      stall = 1'b0;
      #1 chk_idle("post_job");
      if (exp_cycles > 0) chk("busy_cycles", 32'(busy_cnt), 32'(exp_cycles));
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1 chk_idle("reset");
    @(negedge clock);
    reset = 1'b1;

    // nb=1 baseline, nb=2 ordering, stall at k=1 beat 2, write-back backpressure, nb=0
    run_job(1, 0, 100, 0, -1, 0, 0, 13);
    run_job(2, 0, 100, 0, -1, 0, 0, 77);
    run_job(2, 0, 100, 0, 1, 0, 0, 80);
    run_job(1, 0, 100, 0, -1, 5, 0, 18);
    run_job(0, 0, 100, 1, -1, 0, 0, 1);

    // Reset mid-stream at k=1 of a nb=3 job, then a clean full job
    run_job(3, 0, 100, 1, -1, 0, 10, 0);
    @(negedge clock);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clock);
    #1 chk_idle("mid_reset");
    @(negedge clock);
    reset = 1'b1;
    run_job(3, 0, 100, 0, -1, 0, 0, 235);

    for (int r = 0; r < 20; r++)
      run_job($urandom_range(3), 20, 70, 1, -1, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
